// File: rtl/vga_timing_pkg.sv
// Shared timing helpers and standard 800x600 mode constants for the VGA raster generator.
package vga_timing_pkg;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  typedef struct packed {
    int vis;
    int fp;
    int sp;
    int bp;
  } axis_t;

  localparam axis_t SVGA60_H = '{800, 40, 128, 88};
  localparam axis_t SVGA60_V = '{600, 1, 4, 23};
  localparam axis_t VESA72_H = '{800, 56, 120, 64};
  localparam axis_t VESA72_V = '{600, 37, 6, 23};

  function automatic int axis_total(input int vis, input int fp, input int sp, input int bp);
    return vis + fp + sp + bp;
  endfunction

  function automatic int sync_start(input int vis, input int fp);
    return vis + fp;
  endfunction

  function automatic int sync_end(input int vis, input int fp, input int sp);
    return vis + fp + sp;
  endfunction

  // Minimum width able to represent val (at least 1 bit).
  function automatic int coord_bits(input int val);
    for (int w = 1; w < 32; w++)
      if ((val >> w) == 0) return w;
    return 32;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bus between the raster generator (master) and a pixel consumer (slave).
interface vga_timing_gen_if #(
  parameter int COORD_W = 11
) ();
  logic               PIX_CE;
  logic [COORD_W-1:0] PIX_X;
  logic [COORD_W-1:0] PIX_Y;
  logic               PIX_ACTIVE;
  logic               LINE_START;
  logic               FRAME_START;
  logic [7:0]         FRAME_COUNT;
  logic               VGA_HS;
  logic               VGA_VS;
  logic               VGA_DE;

  modport master (
    input  PIX_CE,
    output PIX_X, PIX_Y, PIX_ACTIVE, LINE_START, FRAME_START, FRAME_COUNT,
    output VGA_HS, VGA_VS, VGA_DE
  );

  modport slave (
    output PIX_CE,
    input  PIX_X, PIX_Y, PIX_ACTIVE, LINE_START, FRAME_START, FRAME_COUNT,
    input  VGA_HS, VGA_VS, VGA_DE
  );
endinterface

// File: rtl/vga_sync_delay.sv
// CE-gated shift register of configurable depth; depth 0 is a straight wire.
module vga_sync_delay #(
  parameter int             W       = 3,
  parameter int             DEPTH   = 0,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst, i_ce, RST_VAL};
    assign o_q      = i_d;
  end else begin : g_pipe
    logic [DEPTH-1:0][W-1:0] r_pipe;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_pipe <= {DEPTH{RST_VAL}};
      end else if (i_ce) begin
        r_pipe[0] <= i_d;
        for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
      end
    end

    assign o_q = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, sync decode and an
// optional sync/DE delay line to match a downstream pixel pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE_AREA = 800,
  parameter int   H_FRONT_PORCH  = 40,
  parameter int   H_SYNC_PULSE   = 128,
  parameter int   H_BACK_PORCH   = 88,
  parameter int   V_VISIBLE_AREA = 600,
  parameter int   V_FRONT_PORCH  = 1,
  parameter int   V_SYNC_PULSE   = 4,
  parameter int   V_BACK_PORCH   = 23,
  parameter logic HSYNC_POLARITY = 1'b0,
  parameter logic VSYNC_POLARITY = 1'b0,
  parameter int   COORD_W        = 11,
  parameter int   PIPE_DELAY     = 0
) (
  input  logic             VGA_CLK,
  input  logic             RESET,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL  = axis_total(H_VISIBLE_AREA, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
  localparam int V_TOTAL  = axis_total(V_VISIBLE_AREA, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);
  localparam int HS_START = sync_start(H_VISIBLE_AREA, H_FRONT_PORCH);
  localparam int HS_END   = sync_end(H_VISIBLE_AREA, H_FRONT_PORCH, H_SYNC_PULSE);
  localparam int VS_START = sync_start(V_VISIBLE_AREA, V_FRONT_PORCH);
  localparam int VS_END   = sync_end(V_VISIBLE_AREA, V_FRONT_PORCH, V_SYNC_PULSE);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);

  if (H_VISIBLE_AREA == 0 || H_FRONT_PORCH == 0 || H_SYNC_PULSE == 0 || H_BACK_PORCH == 0 ||
      V_VISIBLE_AREA == 0 || V_FRONT_PORCH == 0 || V_SYNC_PULSE == 0 || V_BACK_PORCH == 0)
  begin : g_err_zero
    $error("vga_timing_gen: every H/V timing parameter must be non-zero");
  end
  if (coord_bits(H_TOTAL - 1) > COORD_W || coord_bits(V_TOTAL - 1) > COORD_W) begin : g_err_width
    $error("vga_timing_gen: COORD_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_err_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..15");
  end

  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_v;
  logic [7:0]         r_frame_cnt;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_active;
  logic               w_line_start;
  sync_t              w_sync_now;
  sync_t              w_sync_dly;

  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_h         <= '0;
      r_v         <= '0;
      r_frame_cnt <= '0;
    end else if (vif.PIX_CE) begin
      if (w_h_wrap) begin
        r_h <= '0;
        if (w_v_wrap) begin
          r_v         <= '0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_v <= r_v + C_ONE;
        end
      end else begin
        r_h <= r_h + C_ONE;
      end
    end
  end

  assign w_active = (r_h < COORD_W'(H_VISIBLE_AREA)) && (r_v < COORD_W'(V_VISIBLE_AREA));

  // Vertical sync decodes v only, so it naturally switches at the h wrap.
  assign w_sync_now.hs = ((r_h >= COORD_W'(HS_START)) && (r_h < COORD_W'(HS_END))) ^ HSYNC_POLARITY;
  assign w_sync_now.vs = ((r_v >= COORD_W'(VS_START)) && (r_v < COORD_W'(VS_END))) ^ VSYNC_POLARITY;
  assign w_sync_now.de = w_active;

  vga_sync_delay #(
    .W       ($bits(sync_t)),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ({HSYNC_POLARITY, VSYNC_POLARITY, 1'b0})
  ) u_sync_delay (
    .i_clk (VGA_CLK),
    .i_rst (RESET),
    .i_ce  (vif.PIX_CE),
    .i_d   (w_sync_now),
    .o_q   (w_sync_dly)
  );

  assign w_line_start = (r_h == '0) && vif.PIX_CE && !RESET;

  assign vif.PIX_X       = r_h;
  assign vif.PIX_Y       = r_v;
  assign vif.PIX_ACTIVE  = w_active;
  assign vif.LINE_START  = w_line_start;
  assign vif.FRAME_START = w_line_start && (r_v == '0);
  assign vif.FRAME_COUNT = r_frame_cnt;
  assign vif.VGA_HS      = w_sync_dly.hs;
  assign vif.VGA_VS      = w_sync_dly.vs;
  assign vif.VGA_DE      = w_sync_dly.de;

endmodule
